issue_ctrl: RTL and testbench
=============================

# issue_ctrl

Issue controller between the instruction decoder and the execute stage. Accepts one decoded instruction per cycle and gates its issue on a register scoreboard: RAW/WAW hazards against outstanding loads, load/store queue occupancy limits, and drain-before-issue serialization for CSR/system and illegal instructions. Tracks outstanding loads and stores until their completions return.

## Interface
- P_ZONE_SZ, 2, width of the zone code (REGFILE / LOADQ / STOREQ, as produced by the decoder)
- P_MAX_LD, 4, maximum outstanding loads; counter width CW_LD = clog2(P_MAX_LD+1)
- P_MAX_ST, 4, maximum outstanding stores; counter width CW_ST = clog2(P_MAX_ST+1)

- clk_i  in  1  clock; all state updates on the rising edge
- resetb_i  in  1  asynchronous, active-low reset
- ids_valid_i  in  1  decoded instruction present
- ids_ready_o  out  1  instruction consumed this cycle (issued or flushed)
- ids_ins_err_i  in  1  illegal-instruction flag from the decoder
- ids_zone_i  in  P_ZONE_SZ  destination zone
- ids_csr_access_i  in  1  CSR/system instruction
- ids_regd_addr_i / ids_regs1_addr_i / ids_regs2_addr_i  in  5 each  rd, rs1, rs2
- exs_valid_o  out  1  issue to execute
- exs_ready_i  in  1  execute can accept
- lq_wb_valid_i  in  1  one load completed (every load, including rd = x0)
- lq_wb_addr_i  in  5  rd of the completed load
- sq_done_i  in  1  one store retired
- flush_i  in  1  discard the presented instruction
- hazard_o  out  1  a valid instruction is blocked by the scoreboard or a limit
- ld_cnt_o  out  CW_LD  outstanding loads
- st_cnt_o  out  CW_ST  outstanding stores

## Operation
- State: pending[31:1] bitmap (x0 never pending), ld_cnt, st_cnt, FSM {RUN, DRAIN}.
- Reset values: pending = 0, ld_cnt = 0, st_cnt = 0, FSM = RUN. Outputs combinational from these: ids_ready_o = 0, exs_valid_o = 0, hazard_o = 0 while ids_valid_i = 0.
- Block conditions (blk):
  - RAW: rs1 != 0 and pending[rs1], or rs2 != 0 and pending[rs2]. Both sources are always checked.
  - WAW: rd != 0 and pending[rd].
  - Load with ld_cnt == P_MAX_LD; store with st_cnt == P_MAX_ST.
  - Serializing instruction (csr_access or ins_err) with ld_cnt != 0 or st_cnt != 0, or FSM = DRAIN.
- hazard_o = ids_valid_i & blk & ~flush_i.
- exs_valid_o = ids_valid_i & ~blk & ~flush_i.
- ids_ready_o = flush_i | (exs_valid_o & exs_ready_i).
- Issue event = exs_valid_o & exs_ready_i.
- Load issue: ld_cnt++. If rd != 0, set pending[rd].
- Store issue: st_cnt++.
- lq_wb_valid_i: ld_cnt--, and clear pending[lq_wb_addr_i].
- sq_done_i: st_cnt--.
- Simultaneous increment and decrement leaves the counter unchanged.
- Same-cycle set and clear of the same pending bit: set wins.
- A completion while the count is 0 is a protocol error; the counter holds at 0.
- FSM:
  - RUN -> DRAIN when a serializing instruction is valid, not flushed, and counts != 0.
  - DRAIN -> RUN when ld_cnt == 0 and st_cnt == 0 (registered values), or on flush_i.
  - In DRAIN, ids_ready_o is driven only by flush_i.
- flush_i does not clear pending bits or counters; in-flight memory operations still complete.

## Timing
- Issue is zero-latency: combinational valid/ready pass-through.
- Scoreboard and counter updates become visible the cycle after the edge.
- Dependent instruction after a load writeback: issues in the writeback cycle only with bypass (see Configuration); otherwise one cycle later.
- Serializing instruction: issues at the earliest one cycle after both counters reach 0 (DRAIN -> RUN, then issue from RUN).
- Reset asserted mid-operation: all state clears immediately (asynchronous). Outstanding completions arriving after reset are ignored by the saturate-at-0 rule.

## Configuration
- ISSUE_CTRL_WB_BYPASS_EN defined:
  - RAW/WAW checks treat pending[r] as cleared when lq_wb_valid_i = 1 and lq_wb_addr_i == r in the same cycle.
  - Serialization checks use the post-decrement counts, so DRAIN exits and RUN-state serializing issue happen in the completion cycle.
- Undefined: all checks use registered state only; one extra stall cycle after each completion.

## Test plan
- Load to x5 issued; next instruction is add x6,x5,x1 -> hazard_o = 1 until lq_wb_valid_i with addr 5. Issue occurs in the writeback cycle with bypass, one cycle later without.
- Five back-to-back loads to distinct rd with no writebacks, P_MAX_LD = 4 -> four issue, ld_cnt_o = 4, fifth blocked (hazard_o = 1). One writeback -> fifth issues, ld_cnt_o stays 4.
- Store outstanding (st_cnt_o = 1) then CSR instruction -> FSM enters DRAIN, ids_ready_o = 0. sq_done_i -> CSR issues; st_cnt_o = 0.
- Load to x0 issued -> no pending bit set, ld_cnt_o = 1. Following add x7,x0,x0 issues immediately.
- Blocked instruction with flush_i = 1 -> ids_ready_o = 1, exs_valid_o = 0, pending bits and counts unchanged.
- resetb_i pulsed low with pending[5] set and ld_cnt_o = 2 -> all outputs clear immediately. A later lq_wb_valid_i leaves ld_cnt_o at 0.

Source files
------------

// File: rtl/issue_ctrl.sv
// Issue controller: load scoreboard, LSQ occupancy limits, drain-before-issue serialization.
// Define ISSUE_CTRL_WB_BYPASS_EN to let same-cycle load completions unblock issue.
module issue_ctrl #(
  parameter int P_ZONE_SZ = 2,
  parameter int P_MAX_LD  = 4,
  parameter int P_MAX_ST  = 4,
  localparam int CW_LD = $clog2(P_MAX_LD + 1),
  localparam int CW_ST = $clog2(P_MAX_ST + 1)
) (
  input  logic                 clk_i,
  input  logic                 resetb_i,
  input  logic                 ids_valid_i,
  output logic                 ids_ready_o,
  input  logic                 ids_ins_err_i,
  input  logic [P_ZONE_SZ-1:0] ids_zone_i,
  input  logic                 ids_csr_access_i,
  input  logic [4:0]           ids_regd_addr_i,
  input  logic [4:0]           ids_regs1_addr_i,
  input  logic [4:0]           ids_regs2_addr_i,
  output logic                 exs_valid_o,
  input  logic                 exs_ready_i,
  input  logic                 lq_wb_valid_i,
  input  logic [4:0]           lq_wb_addr_i,
  input  logic                 sq_done_i,
  input  logic                 flush_i,
  output logic                 hazard_o,
  output logic [CW_LD-1:0]     ld_cnt_o,
  output logic [CW_ST-1:0]     st_cnt_o
);

  localparam logic [P_ZONE_SZ-1:0] Z_LOADQ  = P_ZONE_SZ'(1);
  localparam logic [P_ZONE_SZ-1:0] Z_STOREQ = P_ZONE_SZ'(2);
  localparam logic [CW_LD-1:0]     LD_MAX   = CW_LD'(P_MAX_LD);
  localparam logic [CW_ST-1:0]     ST_MAX   = CW_ST'(P_MAX_ST);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [31:1]      pend_q, pend_d;
  logic [31:1]      clr_m, set_m;
  logic [31:0]      pend_v;
  logic [CW_LD-1:0] ld_q, ld_d, ld_chk;
  logic [CW_ST-1:0] st_q, st_d, st_chk;
  logic             ld_dn, st_dn;
  logic             is_ld, is_st, ser;
  logic             raw, waw, lim, ser_blk, blk, issue;

  assign is_ld = ids_zone_i == Z_LOADQ;
  assign is_st = ids_zone_i == Z_STOREQ;
  assign ser   = ids_csr_access_i | ids_ins_err_i;
  assign ld_dn = lq_wb_valid_i & (ld_q != '0);
  assign st_dn = sq_done_i & (st_q != '0);

  always_comb begin
    clr_m = '0;
    set_m = '0;
    for (int i = 1; i < 32; i++) begin
      clr_m[i] = lq_wb_valid_i & (lq_wb_addr_i == 5'(i));
      set_m[i] = issue & is_ld & (ids_regd_addr_i == 5'(i));
    end
  end

`ifdef ISSUE_CTRL_WB_BYPASS_EN
  assign pend_v = {pend_q & ~clr_m, 1'b0};
  assign ld_chk = ld_q - CW_LD'(ld_dn);
  assign st_chk = st_q - CW_ST'(st_dn);
`else
  assign pend_v = {pend_q, 1'b0};
  assign ld_chk = ld_q;
  assign st_chk = st_q;
`endif

  // pend_v[0] is constant 0, so x0 sources/dest never block
  assign raw = pend_v[ids_regs1_addr_i] | pend_v[ids_regs2_addr_i];
  assign waw = pend_v[ids_regd_addr_i];
  assign lim = (is_ld & (ld_q == LD_MAX)) | (is_st & (st_q == ST_MAX));
  assign ser_blk = ser & ((ld_chk != '0) | (st_chk != '0));
  assign blk = raw | waw | lim | ser_blk | (state_q == DRAIN);

  assign hazard_o    = ids_valid_i & blk & ~flush_i;
  assign exs_valid_o = ids_valid_i & ~blk & ~flush_i;
  assign issue       = exs_valid_o & exs_ready_i;
  assign ids_ready_o = flush_i | issue;
  assign ld_cnt_o    = ld_q;
  assign st_cnt_o    = st_q;

  always_comb begin
    pend_d  = (pend_q & ~clr_m) | set_m;
    ld_d    = ld_q + CW_LD'(issue & is_ld) - CW_LD'(ld_dn);
    st_d    = st_q + CW_ST'(issue & is_st) - CW_ST'(st_dn);
    state_d = state_q;
    unique case (state_q)
      RUN:
        if (ids_valid_i & ~flush_i & ser_blk)
          state_d = DRAIN;
      DRAIN:
        if (flush_i | ((ld_chk == '0) & (st_chk == '0)))
          state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= RUN;
      pend_q  <= '0;
      ld_q    <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural scoreboard model.
module tb_issue_ctrl;

  localparam int MAXLD = 4;
  localparam int MAXST = 4;
`ifdef ISSUE_CTRL_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetb = 1'b1;
  logic       ids_valid = 0, ids_err = 0, ids_csr = 0;
  logic [1:0] ids_zone = 0;
  logic [4:0] ids_rd = 0, ids_rs1 = 0, ids_rs2 = 0;
  logic       exs_ready = 0, lq_wb_valid = 0, sq_done = 0, flush = 0;
  logic [4:0] lq_wb_addr = 0;
  logic       ids_ready, exs_valid, hazard;
  logic [2:0] ld_cnt, st_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_ctrl #(.P_ZONE_SZ(2), .P_MAX_LD(MAXLD), .P_MAX_ST(MAXST)) dut (
    .clk_i(clk), .resetb_i(resetb),
    .ids_valid_i(ids_valid), .ids_ready_o(ids_ready),
    .ids_ins_err_i(ids_err), .ids_zone_i(ids_zone),
    .ids_csr_access_i(ids_csr), .ids_regd_addr_i(ids_rd),
    .ids_regs1_addr_i(ids_rs1), .ids_regs2_addr_i(ids_rs2),
    .exs_valid_o(exs_valid), .exs_ready_i(exs_ready),
    .lq_wb_valid_i(lq_wb_valid), .lq_wb_addr_i(lq_wb_addr),
    .sq_done_i(sq_done), .flush_i(flush), .hazard_o(hazard),
    .ld_cnt_o(ld_cnt), .st_cnt_o(st_cnt)
  );

  // Behavioural model: pending array, plain integer counts, drain flag.
  bit m_pend[32];
  int m_ld = 0, m_st = 0;
  bit m_drain = 0, last_cons = 0;
  int ldq[$];
  int wb_idx = 0;

  function automatic bit is_pend(int r);
    if (r == 0) return 1'b0;
    if (BYP && lq_wb_valid && int'(lq_wb_addr) == r) return 1'b0;
    return m_pend[r];
  endfunction

  function automatic int eff_ld();
    return (BYP && lq_wb_valid && m_ld > 0) ? m_ld - 1 : m_ld;
  endfunction

  function automatic int eff_st();
    return (BYP && sq_done && m_st > 0) ? m_st - 1 : m_st;
  endfunction

  function automatic bit ser();
    return ids_csr || ids_err;
  endfunction

  function automatic bit m_blk();
    return is_pend(ids_rs1) || is_pend(ids_rs2) || is_pend(ids_rd) ||
           (ids_zone == 1 && m_ld == MAXLD) ||
           (ids_zone == 2 && m_st == MAXST) ||
           (ser() && (eff_ld() != 0 || eff_st() != 0)) || m_drain;
  endfunction

  function automatic bit exp_hz();
    return ids_valid && m_blk() && !flush;
  endfunction

  function automatic bit exp_ev();
    return ids_valid && !m_blk() && !flush;
  endfunction

  function automatic bit exp_iss();
    return exp_ev() && exs_ready;
  endfunction

  function automatic bit exp_rdy();
    return flush || exp_iss();
  endfunction

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
      m_ld <= 0;
      m_st <= 0;
      m_drain <= 1'b0;
      last_cons <= 1'b0;
      ldq.delete();
    end else begin
      if (lq_wb_valid) m_pend[lq_wb_addr] <= 1'b0;
      if (exp_iss() && ids_zone == 1 && ids_rd != 0) m_pend[ids_rd] <= 1'b1;
      m_ld <= m_ld + int'(exp_iss() && ids_zone == 1) - int'(lq_wb_valid && m_ld > 0);
      m_st <= m_st + int'(exp_iss() && ids_zone == 2) - int'(sq_done && m_st > 0);
      if (m_drain) begin
        if (flush || (eff_ld() == 0 && eff_st() == 0)) m_drain <= 1'b0;
      end else if (ids_valid && ser() && !flush && (eff_ld() != 0 || eff_st() != 0)) begin
        m_drain <= 1'b1;
      end
      last_cons <= exp_rdy();
      if (lq_wb_valid && wb_idx < ldq.size()) ldq.delete(wb_idx);
      if (exp_iss() && ids_zone == 1) ldq.push_back(int'(ids_rd));
    end
  end

  always @(negedge clk) begin
    chk("hazard_o", hazard, exp_hz());
    chk("exs_valid_o", exs_valid, exp_ev());
    chk("ids_ready_o", ids_ready, exp_rdy());
    chk("ld_cnt_o", ld_cnt, m_ld);
    chk("st_cnt_o", st_cnt, m_st);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(bit v, int z, bit c, int rd, int rs1, int rs2);
    ids_valid = v;
    ids_zone = 2'(z);
    ids_csr = c;
    ids_err = 1'b0;
    ids_rd = 5'(rd);
    ids_rs1 = 5'(rs1);
    ids_rs2 = 5'(rs2);
  endtask

  task automatic wb(bit v, int idx);
    lq_wb_valid = v;
    wb_idx = idx;
    lq_wb_addr = (v && idx < ldq.size()) ? 5'(ldq[idx]) : 5'd0;
  endtask

  initial begin
    #1 resetb = 1'b0;
    nxt();
    nxt();
    chk("rst_ld_cnt", ld_cnt, 0);
    chk("rst_st_cnt", st_cnt, 0);
    chk("rst_ready", ids_ready, 0);
    chk("rst_exs_valid", exs_valid, 0);
    chk("rst_hazard", hazard, 0);
    resetb = 1'b1;
    exs_ready = 1'b1;
    nxt();

    // load x5 then add x6,x5,x1
    ins(1, 1, 0, 5, 1, 2); #2 chk("ld5_issue", exs_valid, 1);
    nxt();
    ins(1, 0, 0, 6, 5, 1); #2 chk("raw_hazard", hazard, 1);
    nxt();
    #2 chk("raw_hazard_hold", hazard, 1);
    nxt();
    wb(1, 0);
`ifdef ISSUE_CTRL_WB_BYPASS_EN
    #2 chk("raw_wb_bypass", exs_valid, 1);
    nxt();
    wb(0, 0); ins(0, 0, 0, 0, 0, 0);
`else
    #2 chk("raw_wb_stall", hazard, 1);
    nxt();
    wb(0, 0);
    #2 chk("raw_after_wb", exs_valid, 1);
    nxt();
    ins(0, 0, 0, 0, 0, 0);
`endif
    #2 chk("raw_ld_cnt", ld_cnt, 0);

    // load queue limit
    for (int i = 0; i < 4; i++) begin
      ins(1, 1, 0, 10 + i, 0, 0); #2 chk("ldq_fill", exs_valid, 1);
      nxt();
    end
    chk("ldq_full_cnt", ld_cnt, 4);
    ins(1, 1, 0, 14, 0, 0); #2 chk("ldq_full_blk", hazard, 1);
    nxt();
    wb(1, 0); #2 chk("ldq_full_wb", hazard, 1);
    nxt();
    wb(0, 0); #2 chk("ldq_fifth_issue", exs_valid, 1);
    nxt();
    ins(0, 0, 0, 0, 0, 0); #2 chk("ldq_still4", ld_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      wb(1, 0);
      nxt();
    end
    wb(0, 0); #2 chk("ldq_drained", ld_cnt, 0);

    // store outstanding then CSR
    ins(1, 2, 0, 0, 1, 2); #2 chk("st_issue", exs_valid, 1);
    nxt();
    ins(1, 0, 1, 3, 0, 0); #2 chk("csr_st_cnt", st_cnt, 1);
    chk("csr_blk", hazard, 1);
    nxt();
    #2 chk("csr_drain_rdy", ids_ready, 0);
    nxt();
    sq_done = 1'b1; #2 chk("csr_done_rdy", ids_ready, 0);
    nxt();
    sq_done = 1'b0;
`ifndef ISSUE_CTRL_WB_BYPASS_EN
    #2 chk("csr_exit_rdy", ids_ready, 0);
    nxt();
`endif
    #2 chk("csr_issue", exs_valid, 1);
    chk("csr_st_zero", st_cnt, 0);
    nxt();
    ins(0, 0, 0, 0, 0, 0);

    // load to x0
    ins(1, 1, 0, 0, 0, 0);
    nxt();
    ins(1, 0, 0, 7, 0, 0); #2 chk("x0_ld_cnt", ld_cnt, 1);
    chk("x0_add_issue", exs_valid, 1);
    nxt();
    ins(0, 0, 0, 0, 0, 0); wb(1, 0);
    nxt();
    wb(0, 0);

    // flush of a blocked instruction
    ins(1, 1, 0, 9, 0, 0);
    nxt();
    ins(1, 0, 0, 8, 9, 0); #2 chk("fl_pre_hazard", hazard, 1);
    flush = 1'b1; #1 chk("fl_ready", ids_ready, 1);
    chk("fl_exs_valid", exs_valid, 0);
    nxt();
    flush = 1'b0; #2 chk("fl_ld_cnt", ld_cnt, 1);
    chk("fl_pend_kept", hazard, 1);

    // async reset mid-operation
    ins(1, 1, 0, 5, 0, 0);
    nxt();
    ins(0, 0, 0, 0, 0, 0); #2 chk("pre_rst_cnt", ld_cnt, 2);
    resetb = 1'b0; #1 chk("async_rst_cnt", ld_cnt, 0);
    chk("async_rst_rdy", ids_ready, 0);
    resetb = 1'b1;
    nxt();
    lq_wb_valid = 1'b1; lq_wb_addr = 5'd5; wb_idx = 0;
    nxt();
    lq_wb_valid = 1'b0;
    ins(1, 0, 0, 6, 5, 9); #2 chk("post_rst_cnt", ld_cnt, 0);
    chk("post_rst_issue", exs_valid, 1);
    nxt();
    ins(0, 0, 0, 0, 0, 0);
    nxt();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!ids_valid || last_cons) begin
        ins($urandom_range(0, 3) != 0, $urandom_range(0, 2),
            $urandom_range(0, 9) == 0, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
        ids_err = $urandom_range(0, 19) == 0;
      end
      exs_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      if (ldq.size() > 0 && $urandom_range(0, 2) == 0)
        wb(1, $urandom_range(0, ldq.size() - 1));
      else if (ldq.size() == 0 && $urandom_range(0, 63) == 0) begin
        lq_wb_valid = 1'b1; lq_wb_addr = 5'($urandom_range(0, 31)); wb_idx = 0;
      end else
        wb(0, 0);
      sq_done = (m_st > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 63) == 0);
      nxt();
    end
    ins(0, 0, 0, 0, 0, 0);
    wb(0, 0);
    sq_done = 1'b0;
    flush = 1'b0;
    nxt();
    nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
